eth_tx_mac: RTL and testbench
=============================

// Module: eth_tx_mac
// PURPOSE
//  10BASE-T Manchester transmitter, parametrised successor to the fixed-length TX. Frame bytes are written into an
//  internal buffer, then transmitted on start: preamble, SFD, payload (optional pad), hardware FCS, TP_IDL, IPG.
//  Emits normal link pulses (NLP) while idle. Sits between the packet builder and the differential line driver.
// PARAMETERS
//  BUF_AW      8       buffer address width; depth = 2**BUF_AW bytes
//  PRE_BYTES   7       preamble bytes of 0x55 before SFD 0xD5
//  NLP_PERIOD  320000  clk_en ticks between link pulses
//  TPIDL_TICKS 6       clk_en ticks of TP_IDL high after FCS
//  IPG_TICKS   193     clk_en ticks of silence after TP_IDL
// PORTS
//  clk        in  1         system clock
//  rst_n      in  1         asynchronous active-low reset
//  clk_en     in  1         20 MHz half-bit strobe; all TX logic advances only when high
//  w_addr     in  BUF_AW    buffer write address
//  w_data     in  8         buffer write data
//  w_en       in  1         buffer write strobe (qualified by clk only, not clk_en)
//  tx_len     in  BUF_AW+1  payload length in bytes, sampled on accepted start
//  start      in  1         request transmission; sampled on clk_en ticks
//  tx_p/tx_n  out 1         differential line outputs
//  tx_busy    out 1         high in every state except LINK
//  tx_done    out 1         one-clk pulse on the IPG->LINK transition
//  start_err  out 1         one-clk pulse when start is rejected
// BEHAVIOUR
//  Reset (rst_n low, async): state=LINK, all counters 0, tx_p=tx_n=0, tx_busy=tx_done=start_err=0.
//  Buffer contents are not reset. Reset mid-frame aborts immediately; no partial FCS is sent.
//  States: LINK -> PRE -> SFD -> DATA -> FCS -> TPIDL -> IPG -> LINK.
//  LINK: nlp_cnt counts 0..NLP_PERIOD-1 and wraps. tx_p=1 and tx_n=0 for the single tick where nlp_cnt==0, else both 0.
//  start is accepted in LINK when tx_len is in 1..2**BUF_AW. The accepted tick enters PRE.
//    tx_len==0 or tx_len>2**BUF_AW: stay in LINK and pulse start_err.
//  Bit timing: each bit spans 2 ticks, LSB first. First half = ~bit, second half = bit.
//    In PRE..FCS, tx_n = ~tx_p. Each byte spans 16 ticks.
//  PRE: PRE_BYTES x 0x55, then SFD: 0xD5, then DATA: buffer[0..N-1].
//  Byte prefetch: the next byte is read at least 1 tick before it is needed, so synchronous RAM read is legal.
//  CRC-32: poly 0x04C11DB7, init 0xFFFFFFFF, loaded in PRE.
//    Updated once per DATA bit, in transmission order, MSB-first LFSR.
//  FCS: ~crc sent bit31 first, 32 bits = 64 ticks.
//  TPIDL: tx_p=1, tx_n=0 for TPIDL_TICKS. IPG: both 0 for IPG_TICKS.
//    Then LINK, tx_done pulses, and nlp_cnt restarts at 0 (NLP on the next tick).
//  w_en writes during tx_busy are dropped. Writes in LINK land immediately and may overlap an accepted start tick.
//  Simultaneous start and w_en on the accept tick: the write lands before byte 0 is prefetched.
//  start while busy: ignored; no error pulse.
// CONFIGURATION
//  ETH_TX_PAD_EN defined: if tx_len<60, N=60.
//    Bytes tx_len..59 are sent as 0x00 and included in the CRC; buffer is not read for pad bytes.
//  ETH_TX_PAD_EN undefined: N=tx_len, no padding. Runt frames go out as-is.
// STRUCTURE
//  Package eth_tx_pkg: state enum, CRC_INIT, CRC_POLY, SFD_BYTE=8'hD5, PRE_BYTE=8'h55, MIN_FRAME=60.
//  Sub-module eth_crc32_bit: one-bit serial CRC step (crc_in, bit_in, en) -> crc_out.
//    Combinational core, register held in parent.
//  Buffer is an inferred 2**BUF_AW x 8 RAM with a synchronous read port.
// TESTING
//  1 Reset, idle 2*NLP_PERIOD ticks -> tx_p pulses exactly 1 tick at tick 0 and NLP_PERIOD; tx_busy=0.
//  2 Write 64 bytes (i), tx_len=64, start -> decoded stream 7x55,D5,00..3F,FCS.
//    FCS matches zlib crc32; CRC over payload+FCS residue=0xC704DD7B.
//  3 tx_len=64 -> tx_busy exactly (8+64+4)*16+6+193 = 1415 ticks; tx_done pulses once at end.
//  4 tx_len=0 and tx_len=2**BUF_AW+1 -> start_err pulse, no activity.
//    tx_len=2**BUF_AW -> full buffer sent.
//  5 tx_len=20: with ETH_TX_PAD_EN, 60 bytes sent (40 zeros) with valid FCS; without it, 20 bytes sent.
//  6 rst_n low mid-DATA -> tx_p=tx_n=0 the same cycle; after release LINK/NLP resumes.
//    A new start sends a correct frame; w_en during busy leaves buffer unchanged.

Source files
------------

// File: rtl/eth_tx_pkg.sv
// Shared definitions for the 10BASE-T transmit MAC.
//   tx_state_e : transmitter FSM states
//   CRC_INIT / CRC_POLY : Ethernet CRC-32 seed and generator (MSB-first form)
//   PRE_BYTE / SFD_BYTE : preamble and start-of-frame-delimiter byte values
//   MIN_FRAME : minimum payload length when padding is enabled
package eth_tx_pkg;

    typedef enum logic [2:0] {
        S_LINK,
        S_PRE,
        S_SFD,
        S_DATA,
        S_FCS,
        S_TPIDL,
        S_IPG
    } tx_state_e;

    localparam logic [31:0] CRC_INIT  = 32'hFFFF_FFFF;
    localparam logic [31:0] CRC_POLY  = 32'h04C1_1DB7;
    localparam logic [7:0]  SFD_BYTE  = 8'hD5;
    localparam logic [7:0]  PRE_BYTE  = 8'h55;
    localparam int          MIN_FRAME = 60;

endpackage

// File: rtl/eth_crc32_bit.sv
// One-bit serial CRC-32 step, MSB-first LFSR. Purely combinational; the CRC
// register itself lives in the parent.
//   crc_in  : current CRC register value
//   bit_in  : data bit to absorb
//   en      : when low, crc_out = crc_in
//   crc_out : updated CRC
module eth_crc32_bit
    import eth_tx_pkg::*;
(
    input  logic [31:0] crc_in,
    input  logic        bit_in,
    input  logic        en,
    output logic [31:0] crc_out
);

    logic fb;

    always_comb begin
        fb      = crc_in[31] ^ bit_in;
        crc_out = crc_in;
        if (en) begin
            crc_out = {crc_in[30:0], 1'b0} ^ (fb ? CRC_POLY : 32'h0);
        end
    end

endmodule

// File: rtl/eth_tx_mac.sv
// 10BASE-T Manchester transmitter. Frame bytes are written into an internal
// buffer, then sent on start as preamble, SFD, payload, FCS, TP_IDL and IPG.
// Normal link pulses are emitted while idle.
// Optional feature macro: ETH_TX_PAD_EN -- pads payloads shorter than 60
// bytes with zeros (included in the FCS).
// Ports:
//   clk, rst_n       : clock, asynchronous active-low reset
//   clk_en           : half-bit strobe; all TX logic advances only when high
//   w_addr/w_data/w_en : buffer write port (clk only, dropped while busy)
//   tx_len           : payload length, sampled on an accepted start
//   start            : transmit request, sampled on clk_en ticks in LINK
//   tx_p/tx_n        : differential line outputs (registered)
//   tx_busy          : high in every state except LINK
//   tx_done          : one-clk pulse on IPG->LINK
//   start_err        : one-clk pulse when start is rejected for a bad length
module eth_tx_mac
    import eth_tx_pkg::*;
#(
    parameter int BUF_AW      = 8,
    parameter int PRE_BYTES   = 7,
    parameter int NLP_PERIOD  = 320000,
    parameter int TPIDL_TICKS = 6,
    parameter int IPG_TICKS   = 193
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clk_en,
    input  logic [BUF_AW-1:0] w_addr,
    input  logic [7:0]        w_data,
    input  logic              w_en,
    input  logic [BUF_AW:0]   tx_len,
    input  logic              start,
    output logic              tx_p,
    output logic              tx_n,
    output logic              tx_busy,
    output logic              tx_done,
    output logic              start_err
);

    localparam int DEPTH = 2 ** BUF_AW;
    // Wide enough for the padded minimum frame even with a tiny buffer.
    localparam int LEN_W = (BUF_AW + 1 > 7) ? BUF_AW + 1 : 7;
    localparam int NLP_W = (NLP_PERIOD > 1) ? $clog2(NLP_PERIOD) : 1;
    localparam int CNT_W = $clog2(IPG_TICKS + TPIDL_TICKS + 64);

    tx_state_e         state, state_d;
    logic [NLP_W-1:0]  nlp_cnt, nlp_d;
    logic [CNT_W-1:0]  cnt, cnt_d;
    logic [LEN_W-1:0]  byte_cnt, byte_d, frame_n, frame_d, pay_len, len_d;
    logic [BUF_AW-1:0] rd_ptr, ptr_d;
    logic [7:0]        cur_byte, cur_d, rd_data, sel_byte;
    logic [31:0]       crc, crc_d, crc_next;
    logic              p_d, n_d, done_d, err_d;
    logic              tx_bit, man, crc_en, len_ok, last_byte_tick;

    logic [7:0] mem [DEPTH];

    assign tx_busy = (state != S_LINK);

    // Read port runs every clk, so rd_data always reflects mem[rd_ptr] one
    // clk after rd_ptr moves -- far ahead of the 16-tick byte boundary.
    always_ff @(posedge clk) begin
        if (w_en && !tx_busy) mem[w_addr] <= w_data;
        rd_data <= mem[rd_ptr];
    end

    assign len_ok         = (tx_len != '0) && (tx_len <= (BUF_AW + 1)'(DEPTH));
    assign last_byte_tick = (cnt[3:0] == 4'hF);
    assign sel_byte       = (state == S_PRE) ? PRE_BYTE :
                            (state == S_SFD) ? SFD_BYTE : cur_byte;
    // FCS goes out as ~crc, bit 31 first; ~idx == 31-idx for a 5-bit index.
    assign tx_bit         = (state == S_FCS) ? ~crc[~cnt[5:1]] : sel_byte[cnt[3:1]];
    // Absorb each payload bit once, on its second half-bit tick.
    assign crc_en         = (state == S_DATA) && cnt[0];

    eth_crc32_bit u_crc (
        .crc_in  (crc),
        .bit_in  (tx_bit),
        .en      (crc_en),
        .crc_out (crc_next)
    );

    always_comb begin
        state_d = state;
        nlp_d   = nlp_cnt;
        cnt_d   = cnt;
        byte_d  = byte_cnt;
        frame_d = frame_n;
        len_d   = pay_len;
        ptr_d   = rd_ptr;
        cur_d   = cur_byte;
        crc_d   = crc;
        p_d     = tx_p;
        n_d     = tx_n;
        done_d  = 1'b0;
        err_d   = 1'b0;
        man     = 1'b0;
        if (clk_en) begin
            p_d = 1'b0;
            n_d = 1'b0;
            case (state)
                S_LINK: begin
                    nlp_d = (nlp_cnt == NLP_W'(NLP_PERIOD - 1)) ? '0 : nlp_cnt + 1'b1;
                    if (start && len_ok) begin
                        state_d = S_PRE;
                        nlp_d   = '0;
                        cnt_d   = '0;
                        byte_d  = '0;
                        ptr_d   = '0;
                        len_d   = LEN_W'(tx_len);
`ifdef ETH_TX_PAD_EN
                        frame_d = (LEN_W'(tx_len) < LEN_W'(MIN_FRAME)) ?
                                  LEN_W'(MIN_FRAME) : LEN_W'(tx_len);
`else
                        frame_d = LEN_W'(tx_len);
`endif
                    end else begin
                        p_d   = (nlp_cnt == '0);
                        err_d = start;
                    end
                end
                S_PRE: begin
                    man   = 1'b1;
                    crc_d = CRC_INIT;
                    cnt_d = cnt + 1'b1;
                    if (last_byte_tick) begin
                        cnt_d  = '0;
                        byte_d = byte_cnt + 1'b1;
                        if (byte_cnt == LEN_W'(PRE_BYTES - 1)) begin
                            state_d = S_SFD;
                            byte_d  = '0;
                        end
                    end
                end
                S_SFD: begin
                    man   = 1'b1;
                    cnt_d = cnt + 1'b1;
                    if (last_byte_tick) begin
                        cnt_d   = '0;
                        state_d = S_DATA;
                        cur_d   = rd_data;
                        ptr_d   = rd_ptr + 1'b1;
                    end
                end
                S_DATA: begin
                    man   = 1'b1;
                    crc_d = crc_next;
                    cnt_d = cnt + 1'b1;
                    if (last_byte_tick) begin
                        cnt_d  = '0;
                        byte_d = byte_cnt + 1'b1;
                        if (byte_cnt == frame_n - LEN_W'(1)) begin
                            state_d = S_FCS;
                            byte_d  = '0;
                        end else begin
                            // Past the payload only pad bytes remain.
                            cur_d = ((byte_cnt + LEN_W'(1)) < pay_len) ? rd_data : 8'h00;
                            ptr_d = rd_ptr + 1'b1;
                        end
                    end
                end
                S_FCS: begin
                    man   = 1'b1;
                    cnt_d = cnt + 1'b1;
                    if (cnt == CNT_W'(63)) begin
                        cnt_d   = '0;
                        state_d = S_TPIDL;
                    end
                end
                S_TPIDL: begin
                    p_d   = 1'b1;
                    cnt_d = cnt + 1'b1;
                    if (cnt == CNT_W'(TPIDL_TICKS - 1)) begin
                        cnt_d   = '0;
                        state_d = S_IPG;
                    end
                end
                S_IPG: begin
                    cnt_d = cnt + 1'b1;
                    if (cnt == CNT_W'(IPG_TICKS - 1)) begin
                        cnt_d   = '0;
                        nlp_d   = '0;
                        state_d = S_LINK;
                        done_d  = 1'b1;
                    end
                end
                default: state_d = S_LINK;
            endcase
            // Manchester: first half ~bit, second half bit.
            if (man) begin
                p_d = cnt[0] ? tx_bit : ~tx_bit;
                n_d = ~p_d;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_LINK;
            nlp_cnt   <= '0;
            cnt       <= '0;
            byte_cnt  <= '0;
            frame_n   <= '0;
            pay_len   <= '0;
            rd_ptr    <= '0;
            cur_byte  <= '0;
            crc       <= '0;
            tx_p      <= 1'b0;
            tx_n      <= 1'b0;
            tx_done   <= 1'b0;
            start_err <= 1'b0;
        end else begin
            state     <= state_d;
            nlp_cnt   <= nlp_d;
            cnt       <= cnt_d;
            byte_cnt  <= byte_d;
            frame_n   <= frame_d;
            pay_len   <= len_d;
            rd_ptr    <= ptr_d;
            cur_byte  <= cur_d;
            crc       <= crc_d;
            tx_p      <= p_d;
            tx_n      <= n_d;
            tx_done   <= done_d;
            start_err <= err_d;
        end
    end

endmodule

// File: tb/tb_eth_tx_mac.sv
module tb_eth_tx_mac;
    localparam int AW    = 6;
    localparam int DEPTH = 64;
    localparam int NLP   = 200;
    localparam int TPI   = 6;
    localparam int IPG   = 193;
`ifdef ETH_TX_PAD_EN
    localparam bit PAD = 1'b1;
`else
    localparam bit PAD = 1'b0;
`endif

    logic          clk = 1'b0, rst_n = 1'b0, clk_en = 1'b0, w_en = 1'b0, start = 1'b0;
    logic [AW-1:0] w_addr = '0;
    logic [7:0]    w_data = '0;
    logic [AW:0]   tx_len = '0;
    logic          tx_p, tx_n, tx_busy, tx_done, start_err;

    int errors = 0;
    int checks = 0;

    logic [7:0] mem_m [DEPTH];
    logic       p_s   [0:4199];
    logic       n_s   [0:4199];
    logic [7:0] dec   [0:127];
    logic [7:0] expb  [0:127];

    typedef struct {
        int len;
        bit err;
        int n;
    } vec_t;
    vec_t vt [7];

    eth_tx_mac #(
        .BUF_AW(AW), .PRE_BYTES(7), .NLP_PERIOD(NLP),
        .TPIDL_TICKS(TPI), .IPG_TICKS(IPG)
    ) dut (
        .clk(clk), .rst_n(rst_n), .clk_en(clk_en),
        .w_addr(w_addr), .w_data(w_data), .w_en(w_en),
        .tx_len(tx_len), .start(start),
        .tx_p(tx_p), .tx_n(tx_n), .tx_busy(tx_busy),
        .tx_done(tx_done), .start_err(start_err)
    );

    always #5 clk = ~clk;

    // Half-bit strobe on every other clk.
    initial forever begin
        @(negedge clk);
        clk_en = ~clk_en;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Advance to just after the next clk_en tick edge.
    task automatic tick();
        do @(posedge clk); while (!clk_en);
        #1;
    endtask

    // Leave the bench so that the next posedge is a tick edge.
    task automatic to_slot();
        tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input int a, input logic [7:0] d);
        w_addr = AW'(a);
        w_data = d;
        w_en   = 1'b1;
        @(posedge clk);
        #1;
        w_en = 1'b0;
    endtask

    // Reference reflected CRC-32 (zlib form).
    function automatic logic [31:0] crc32z(input logic [7:0] a [0:127], input int from, input int cnt);
        logic [31:0] c;
        c = 32'hFFFF_FFFF;
        for (int j = from; j < from + cnt; j++) begin
            c ^= {24'h0, a[j]};
            for (int i = 0; i < 8; i++) c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
        end
        return ~c;
    endfunction

    task automatic send_err(input int len);
        int busy_cnt;
        busy_cnt = 0;
        to_slot();
        tx_len = (AW + 1)'(len);
        start  = 1'b1;
        tick();
        start = 1'b0;
        check($sformatf("start_err_len%0d", len), start_err, 1'b1);
        busy_cnt += int'(tx_busy);
        for (int k = 0; k < 20; k++) begin
            tick();
            busy_cnt += int'(tx_busy);
        end
        check($sformatf("no_activity_len%0d", len), busy_cnt, 0);
    endtask

    task automatic send(input int len, input int n, input bit poke, input bit wa);
        int busy_cnt, done_cnt, done_k, err_cnt, man_bad, byte_bad, tail_bad, nb, m, bexp, s;
        logic [7:0] b;
        logic [31:0] fcs;
        busy_cnt = 0; done_cnt = 0; done_k = -1; err_cnt = 0;
        man_bad = 0; byte_bad = 0; tail_bad = 0;
        to_slot();
        tx_len = (AW + 1)'(len);
        start  = 1'b1;
        if (wa) begin
            w_en = 1'b1; w_addr = '0; w_data = 8'hA5; mem_m[0] = 8'hA5;
        end
        tick();
        start = 1'b0;
        w_en  = 1'b0;
        p_s[0] = tx_p; n_s[0] = tx_n;
        busy_cnt += int'(tx_busy);
        for (int k = 1; k < 4000; k++) begin
            if (poke && k == 100) begin
                w_en = 1'b1; w_addr = AW'(1); w_data = 8'hEE;
            end
            tick();
            w_en = 1'b0;
            p_s[k] = tx_p; n_s[k] = tx_n;
            busy_cnt += int'(tx_busy);
            err_cnt  += int'(start_err);
            if (tx_done) begin
                done_cnt++;
                if (done_k < 0) done_k = k;
            end
            if (done_k >= 0 && k == done_k + 1) break;
        end
        nb   = 12 + n;
        m    = nb * 16;
        bexp = m + TPI + IPG;
        // expected byte stream
        for (int j = 0; j < 7; j++) expb[j] = 8'h55;
        expb[7] = 8'hD5;
        for (int j = 0; j < n; j++) expb[8 + j] = (j < len) ? mem_m[j] : 8'h00;
        fcs = crc32z(expb, 8, n);
        for (int j = 0; j < 4; j++) expb[8 + n + j] = fcs[8*j +: 8];
        // decode the line
        for (int j = 0; j < nb; j++) begin
            b = '0;
            for (int i = 0; i < 8; i++) begin
                s = 1 + 16 * j + 2 * i;
                if (p_s[s] === p_s[s + 1]) man_bad++;
                if (n_s[s] !== ~p_s[s] || n_s[s + 1] !== ~p_s[s + 1]) man_bad++;
                b[i] = p_s[s + 1];
            end
            dec[j] = b;
            if (b !== expb[j]) begin
                if (byte_bad == 0)
                    $display("FAIL frame_byte[%0d] len%0d: got %0h expected %0h", j, len, b, expb[j]);
                byte_bad++;
            end
        end
        for (int k = m + 1; k <= bexp; k++) begin
            if (k <= m + TPI) begin
                if (p_s[k] !== 1'b1 || n_s[k] !== 1'b0) tail_bad++;
            end else if (p_s[k] !== 1'b0 || n_s[k] !== 1'b0) tail_bad++;
        end
        check($sformatf("busy_ticks_len%0d", len), busy_cnt, bexp);
        check($sformatf("done_count_len%0d", len), done_cnt, 1);
        check($sformatf("done_at_len%0d", len), done_k, bexp);
        check($sformatf("no_err_len%0d", len), err_cnt, 0);
        check($sformatf("manchester_len%0d", len), man_bad, 0);
        check($sformatf("bytes_len%0d", len), byte_bad, 0);
        check($sformatf("fcs_len%0d", len), {dec[nb-1], dec[nb-2], dec[nb-3], dec[nb-4]}, fcs);
        check($sformatf("residue_len%0d", len), crc32z(dec, 8, n + 4), 32'h2144_DF1C);
        check($sformatf("tpidl_ipg_len%0d", len), tail_bad, 0);
        if (done_k >= 0) check($sformatf("nlp_after_len%0d", len), p_s[done_k + 1], 1'b1);
        else check($sformatf("nlp_after_len%0d", len), 1'b0, 1'b1);
    endtask

    initial begin
        int pulses, busy_cnt, nbad, k;
        vt[0] = '{0, 1'b1, 0};
        vt[1] = '{65, 1'b1, 0};
        vt[2] = '{127, 1'b1, 0};
        vt[3] = '{64, 1'b0, 64};
        vt[4] = '{20, 1'b0, PAD ? 60 : 20};
        vt[5] = '{1, 1'b0, PAD ? 60 : 1};
        vt[6] = '{60, 1'b0, 60};

        // reset state
        repeat (4) @(posedge clk);
        #1;
        check("reset_outs", {tx_p, tx_n, tx_busy, tx_done, start_err}, 5'b0);
        rst_n = 1'b1;

        // idle link pulses
        pulses = 0; busy_cnt = 0; nbad = 0;
        for (int t = 0; t < 2 * NLP; t++) begin
            tick();
            pulses   += int'(tx_p);
            busy_cnt += int'(tx_busy);
            nbad     += int'(tx_n);
            if (t == 0)   check("nlp_tick0", tx_p, 1'b1);
            if (t == NLP) check("nlp_tickP", tx_p, 1'b1);
        end
        check("nlp_pulses", pulses, 2);
        check("nlp_busy", busy_cnt, 0);
        check("nlp_txn", nbad, 0);

        for (int i = 0; i < DEPTH; i++) begin
            mem_m[i] = 8'(i);
            wr(i, 8'(i));
        end

        for (int v = 0; v < 7; v++) begin
            if (vt[v].err) send_err(vt[v].len);
            else send(vt[v].len, vt[v].n, 1'b0, 1'b0);
        end

        // write during busy is dropped; write on accept tick lands first
        send(64, 64, 1'b1, 1'b0);
        send(64, 64, 1'b0, 1'b1);

        // reset mid-DATA
        to_slot();
        tx_len = (AW + 1)'(64);
        start  = 1'b1;
        tick();
        start = 1'b0;
        k = 0;
        while (k < 400 && !(k >= 200 && tx_p === 1'b1)) begin
            tick();
            k++;
        end
        check("mid_data_reached", (k < 400), 1'b1);
        rst_n = 1'b0;
        #1;
        check("rst_mid_outs", {tx_p, tx_n, tx_busy}, 3'b0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick();
        check("nlp_resume", {tx_p, tx_n, tx_busy}, 3'b100);
        send(64, 64, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
